// File: rtl/jpeg_pad_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_pad_serializer
//  Description : Buffers 32-bit JPEG words plus the EOF partial word and
//                serializes them MSB-first onto a narrow valid/ready pad bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_pad_serializer #(
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              JPEG_bitstream,
    input  logic                     data_ready,
    input  logic [4:0]               end_of_file_bitstream_count,
    input  logic                     eof_data_partial_ready,
    input  logic                     pad_rdy_i,
    output logic [OUT_W-1:0]         pad_dat_o,
    output logic                     pad_vld_o,
    output logic                     pad_last_o,
    output logic [4:0]               pad_eof_cnt_o,
    output logic                     ovf_o,
    output logic [$clog2(DEPTH):0]   fifo_lvl_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int BEATS = 32 / OUT_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OSH   = $clog2(OUT_W);
    localparam int EW    = 38;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic             ovf_q, ovf_d;
    logic [OUT_W-1:0] pad_dat_q, pad_dat_d;
    logic             pad_last_q, pad_last_d;
    logic [4:0]       pad_eof_cnt_q, pad_eof_cnt_d;

    logic [EW-1:0]    head, e_full, e_eof, nxt_entry;
    logic             nxt_valid, accept, pop, push_full, push_eof;
    logic [LW-1:0]    free_slots;
    logic [5:0]       sh;
    logic [31:0]      shifted;

    // Index of the final beat: EOF entries send only the beats covering count.
    function automatic logic [BCW-1:0] last_idx(input logic [EW-1:0] e);
        logic [4:0] cnt;
        cnt = e[36:32];
        if (!e[37])
            return BCW'(BEATS - 1);
        if (cnt == 5'd0)
            return '0;
        return BCW'((cnt - 5'd1) >> OSH);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            lvl_q         <= '0;
            bcnt_q        <= '0;
            ovf_q         <= 1'b0;
            pad_dat_q     <= '0;
            pad_last_q    <= 1'b0;
            pad_eof_cnt_q <= 5'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= mem_d[i];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            lvl_q         <= lvl_d;
            bcnt_q        <= bcnt_d;
            ovf_q         <= ovf_d;
            pad_dat_q     <= pad_dat_d;
            pad_last_q    <= pad_last_d;
            pad_eof_cnt_q <= pad_eof_cnt_d;
        end
    end

    // Next state: FIFO bookkeeping and selection of the entry/beat shown next cycle.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        accept     = (state_q == S_SEND) && pad_rdy_i;
        pop        = accept && (bcnt_q == last_idx(head));
        free_slots = LW'(DEPTH) - lvl_q + LW'(pop);
        push_full  = data_ready && (free_slots != '0);
        push_eof   = eof_data_partial_ready &&
                     (free_slots >= (data_ready ? LW'(2) : LW'(1)));
        ovf_d      = ovf_q | (data_ready & ~push_full) |
                     (eof_data_partial_ready & ~push_eof);

        // Stored EOF data is pre-masked so tail bits beyond count read as zero.
        e_full = {1'b0, 5'd0, JPEG_bitstream};
        e_eof  = {1'b1, end_of_file_bitstream_count,
                  JPEG_bitstream & ~(32'hFFFF_FFFF >> end_of_file_bitstream_count)};

        mem_d = mem_q;
        if (push_full)
            mem_d[wr_ptr_q] = e_full;
        if (push_eof)
            mem_d[push_full ? wr_ptr_q + AW'(1) : wr_ptr_q] = e_eof;

        wr_ptr_d = wr_ptr_q + AW'(push_full) + AW'(push_eof);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        lvl_d    = lvl_q - LW'(pop) + LW'(push_full) + LW'(push_eof);

        nxt_valid = 1'b1;
        nxt_entry = head;
        if ((state_q == S_SEND) && !pop) begin
            bcnt_d = bcnt_q + BCW'(accept);
        end else begin
            bcnt_d = '0;
            // Bypass a fresh write straight to the output when nothing is queued.
            if ((lvl_q - LW'(pop)) != '0)
                nxt_entry = mem_q[rd_ptr_d];
            else if (push_full)
                nxt_entry = e_full;
            else if (push_eof)
                nxt_entry = e_eof;
            else
                nxt_valid = 1'b0;
        end
        state_d = nxt_valid ? S_SEND : S_IDLE;
    end

    always_comb begin
        sh            = 6'(bcnt_d) * 6'(OUT_W);
        shifted       = nxt_entry[31:0] << sh;
        pad_dat_d     = nxt_valid ? shifted[31 -: OUT_W] : '0;
        pad_last_d    = nxt_valid && nxt_entry[37] && (bcnt_d == last_idx(nxt_entry));
        pad_eof_cnt_d = pad_last_d ? nxt_entry[36:32] : 5'd0;
    end

    assign pad_vld_o     = (state_q == S_SEND);
    assign pad_dat_o     = pad_dat_q;
    assign pad_last_o    = pad_last_q;
    assign pad_eof_cnt_o = pad_eof_cnt_q;
    assign ovf_o         = ovf_q;
    assign fifo_lvl_o    = lvl_q;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_pad_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jpeg_pad_serializer
//  Description : Directed self-checking bench for jpeg_pad_serializer with
//                an 8-bit and a 16-bit pad instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_pad_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] d8_word;  logic d8_dr, d8_er, d8_rdy;  logic [4:0] d8_cnt;
    logic [7:0]  d8_dat;   logic d8_vld, d8_last, d8_ovf; logic [4:0] d8_ecnt; logic [2:0] d8_lvl;
    logic [31:0] d16_word; logic d16_dr, d16_er, d16_rdy; logic [4:0] d16_cnt;
    logic [15:0] d16_dat;  logic d16_vld, d16_last, d16_ovf; logic [4:0] d16_ecnt; logic [2:0] d16_lvl;

    int n_checks = 0;
    int n_fail   = 0;

    jpeg_pad_serializer #(.OUT_W(8), .DEPTH(4)) u_dut8 (
        .clk(clk), .rst(rst), .JPEG_bitstream(d8_word), .data_ready(d8_dr),
        .end_of_file_bitstream_count(d8_cnt), .eof_data_partial_ready(d8_er),
        .pad_rdy_i(d8_rdy), .pad_dat_o(d8_dat), .pad_vld_o(d8_vld), .pad_last_o(d8_last),
        .pad_eof_cnt_o(d8_ecnt), .ovf_o(d8_ovf), .fifo_lvl_o(d8_lvl)
    );

    jpeg_pad_serializer #(.OUT_W(16), .DEPTH(4)) u_dut16 (
        .clk(clk), .rst(rst), .JPEG_bitstream(d16_word), .data_ready(d16_dr),
        .end_of_file_bitstream_count(d16_cnt), .eof_data_partial_ready(d16_er),
        .pad_rdy_i(d16_rdy), .pad_dat_o(d16_dat), .pad_vld_o(d16_vld), .pad_last_o(d16_last),
        .pad_eof_cnt_o(d16_ecnt), .ovf_o(d16_ovf), .fifo_lvl_o(d16_lvl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d8_word = '0;  d8_dr = 0;  d8_er = 0;  d8_cnt = '0;  d8_rdy = 0;
        d16_word = '0; d16_dr = 0; d16_er = 0; d16_cnt = '0; d16_rdy = 0;
        tick(); tick();
        n_checks++;
        if ({d8_vld, d8_last, d8_dat, d8_ecnt, d8_ovf, d8_lvl} !== '0) begin
            n_fail++;
            $display("FAIL reset8: got vld=%b last=%b dat=%h ecnt=%0d ovf=%b lvl=%0d, expected all 0",
                     d8_vld, d8_last, d8_dat, d8_ecnt, d8_ovf, d8_lvl);
        end
        n_checks++;
        if ({d16_vld, d16_last, d16_dat, d16_ecnt, d16_ovf, d16_lvl} !== '0) begin
            n_fail++;
            $display("FAIL reset16: got vld=%b last=%b dat=%h ecnt=%0d ovf=%b lvl=%0d, expected all 0",
                     d16_vld, d16_last, d16_dat, d16_ecnt, d16_ovf, d16_lvl);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        w = 32'hDEAD_BEEF;
        d8_rdy = 1; d8_word = w; d8_dr = 1;
        tick();
        d8_dr = 0;
        n_checks++;
        if (d8_lvl !== 3'd1) begin
            n_fail++; $display("FAIL single_lvl: got %0d expected 1", d8_lvl);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({d8_vld, d8_last, d8_dat} !== {1'b1, 1'b0, w[31-8*k -: 8]}) begin
                n_fail++;
                $display("FAIL single_beat%0d: got vld=%b last=%b dat=%h expected 1 0 %h",
                         k, d8_vld, d8_last, d8_dat, w[31-8*k -: 8]);
            end
            tick();
        end
        n_checks++;
        if ({d8_vld, d8_lvl} !== 4'b0) begin
            n_fail++; $display("FAIL single_end: got vld=%b lvl=%0d expected 0 0", d8_vld, d8_lvl);
        end
    endtask

    task automatic test_eof();
        d8_rdy = 1; d8_word = 32'hABCD_EF12; d8_cnt = 5'd13; d8_er = 1;
        tick();
        d8_er = 0;
        n_checks++;
        if ({d8_vld, d8_last, d8_dat, d8_ecnt} !== {1'b1, 1'b0, 8'hAB, 5'd0}) begin
            n_fail++; $display("FAIL eof13_b0: got vld=%b last=%b dat=%h ecnt=%0d expected 1 0 ab 0",
                               d8_vld, d8_last, d8_dat, d8_ecnt);
        end
        tick();
        n_checks++;
        if ({d8_vld, d8_last, d8_dat, d8_ecnt} !== {1'b1, 1'b1, 8'hC8, 5'd13}) begin
            n_fail++; $display("FAIL eof13_b1: got vld=%b last=%b dat=%h ecnt=%0d expected 1 1 c8 13",
                               d8_vld, d8_last, d8_dat, d8_ecnt);
        end
        tick();
        n_checks++;
        if (d8_vld !== 1'b0) begin
            n_fail++; $display("FAIL eof13_end: got vld=%b expected 0", d8_vld);
        end
        d8_word = 32'hFFFF_FFFF; d8_cnt = 5'd0; d8_er = 1;
        tick();
        d8_er = 0;
        n_checks++;
        if ({d8_vld, d8_last, d8_dat, d8_ecnt} !== {1'b1, 1'b1, 8'h00, 5'd0}) begin
            n_fail++; $display("FAIL eof0_b0: got vld=%b last=%b dat=%h ecnt=%0d expected 1 1 00 0",
                               d8_vld, d8_last, d8_dat, d8_ecnt);
        end
        tick();
        n_checks++;
        if (d8_vld !== 1'b0) begin
            n_fail++; $display("FAIL eof0_end: got vld=%b expected 0", d8_vld);
        end
    endtask

    task automatic test_dual_strobe();
        logic [13:0] exp_b [6];
        // {last, dat, ecnt}: full word, then EOF copy masked to 12 bits
        exp_b[0] = {1'b0, 8'h11, 5'd0};  exp_b[1] = {1'b0, 8'h22, 5'd0};
        exp_b[2] = {1'b0, 8'h33, 5'd0};  exp_b[3] = {1'b0, 8'h44, 5'd0};
        exp_b[4] = {1'b0, 8'h11, 5'd0};  exp_b[5] = {1'b1, 8'h20, 5'd12};
        d8_rdy = 1; d8_word = 32'h1122_3344; d8_cnt = 5'd12; d8_dr = 1; d8_er = 1;
        tick();
        d8_dr = 0; d8_er = 0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if ({d8_vld, d8_last, d8_dat, d8_ecnt} !== {1'b1, exp_b[k]}) begin
                n_fail++;
                $display("FAIL dual_beat%0d: got vld=%b last=%b dat=%h ecnt=%0d expected {last,dat,ecnt}=%h",
                         k, d8_vld, d8_last, d8_dat, d8_ecnt, exp_b[k]);
            end
            tick();
        end
        n_checks++;
        if ({d8_vld, d8_lvl} !== 4'b0) begin
            n_fail++; $display("FAIL dual_end: got vld=%b lvl=%0d expected 0 0", d8_vld, d8_lvl);
        end
    endtask

    task automatic test_overflow16();
        int beats;
        logic [15:0] exp_h;
        d16_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            d16_word = {16'hA000 + 16'(i), 16'hB000 + 16'(i)};
            d16_dr = 1;
            tick();
        end
        d16_dr = 0;
        n_checks++;
        if ({d16_lvl, d16_ovf} !== {3'd4, 1'b1}) begin
            n_fail++; $display("FAIL ovf16_full: got lvl=%0d ovf=%b expected 4 1", d16_lvl, d16_ovf);
        end
        n_checks++;
        if ({d16_vld, d16_dat} !== {1'b1, 16'hA000}) begin
            n_fail++; $display("FAIL ovf16_stall: got vld=%b dat=%h expected 1 a000", d16_vld, d16_dat);
        end
        d16_rdy = 1;
        beats = 0;
        for (int c = 0; c < 12; c++) begin
            if (d16_vld) begin
                exp_h = (beats % 2 == 0) ? 16'hA000 + 16'(beats / 2) : 16'hB000 + 16'(beats / 2);
                n_checks++;
                if (beats >= 8 || d16_dat !== exp_h) begin
                    n_fail++; $display("FAIL ovf16_beat%0d: got dat=%h expected %h (8 beats max)",
                                       beats, d16_dat, exp_h);
                end
                beats++;
            end
            tick();
        end
        n_checks++;
        if (beats != 8 || d16_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf16_count: got beats=%0d ovf=%b expected 8 1", beats, d16_ovf);
        end
    endtask

    task automatic test_eof_drop();
        int beats, lasts;
        d8_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            d8_word = 32'h0101_0101 * (i + 1); d8_dr = 1;
            tick();
        end
        d8_word = 32'h7777_7777; d8_cnt = 5'd5; d8_dr = 1; d8_er = 1;
        tick();
        d8_dr = 0; d8_er = 0;
        n_checks++;
        if ({d8_lvl, d8_ovf} !== {3'd4, 1'b1}) begin
            n_fail++; $display("FAIL drop_full: got lvl=%0d ovf=%b expected 4 1", d8_lvl, d8_ovf);
        end
        d8_rdy = 1;
        beats = 0; lasts = 0;
        for (int c = 0; c < 20; c++) begin
            if (d8_vld) beats++;
            if (d8_vld && d8_last) lasts++;
            tick();
        end
        n_checks++;
        if (beats != 16 || lasts != 0) begin
            n_fail++; $display("FAIL drop_drain: got beats=%0d lasts=%0d expected 16 0", beats, lasts);
        end
    endtask

    task automatic test_random_ready();
        logic [31:0] words [64];
        logic [31:0] wsel;
        logic        held;
        logic [7:0]  held_dat;
        int sent, bi, cyc;
        sent = 0; bi = 0; cyc = 0; held = 0; held_dat = '0;
        while (bi < 256 && cyc < 4000) begin
            if (held) begin
                n_checks++;
                if (d8_vld !== 1'b1 || d8_dat !== held_dat) begin
                    n_fail++; $display("FAIL rand_stall: got vld=%b dat=%h expected 1 %h", d8_vld, d8_dat, held_dat);
                end
            end
            if (d8_lvl != 3'd0) begin
                n_checks++;
                if (d8_vld !== 1'b1) begin
                    n_fail++; $display("FAIL rand_gap: got vld=%b with lvl=%0d expected 1", d8_vld, d8_lvl);
                end
            end
            d8_rdy = 1'($urandom_range(0, 1));
            if (d8_vld && d8_rdy) begin
                wsel = words[bi / 4];
                n_checks++;
                if (d8_dat !== wsel[31-8*(bi%4) -: 8]) begin
                    n_fail++; $display("FAIL rand_beat%0d: got %h expected %h", bi, d8_dat, wsel[31-8*(bi%4) -: 8]);
                end
                bi++;
            end
            held = d8_vld && !d8_rdy;
            held_dat = d8_dat;
            if (sent < 64 && d8_lvl < 3'd4 && $urandom_range(0, 3) != 0) begin
                words[sent] = $urandom;
                d8_word = words[sent];
                d8_dr = 1;
                sent++;
            end else begin
                d8_dr = 0;
            end
            tick();
            cyc++;
        end
        d8_dr = 0; d8_rdy = 1;
        n_checks++;
        if (bi != 256) begin
            n_fail++; $display("FAIL rand_timeout: got %0d beats expected 256", bi);
        end
    endtask

    task automatic test_reset_midword();
        logic [31:0] w;
        d8_rdy = 1; d8_word = 32'hCAFE_BABE; d8_dr = 1;
        tick();
        d8_dr = 0;
        tick();
        n_checks++;
        if ({d8_vld, d8_dat} !== {1'b1, 8'hFE}) begin
            n_fail++; $display("FAIL rstmid_beat1: got vld=%b dat=%h expected 1 fe", d8_vld, d8_dat);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({d8_vld, d8_last, d8_dat, d8_ecnt, d8_ovf, d8_lvl} !== '0) begin
            n_fail++; $display("FAIL rstmid_clear: got vld=%b last=%b dat=%h ecnt=%0d ovf=%b lvl=%0d expected all 0",
                               d8_vld, d8_last, d8_dat, d8_ecnt, d8_ovf, d8_lvl);
        end
        #3 rst = 1'b0;
        tick();
        w = 32'h0102_0304;
        d8_word = w; d8_dr = 1;
        tick();
        d8_dr = 0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({d8_vld, d8_dat} !== {1'b1, w[31-8*k -: 8]}) begin
                n_fail++; $display("FAIL rstmid_new%0d: got vld=%b dat=%h expected 1 %h", k, d8_vld, d8_dat, w[31-8*k -: 8]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_eof();
        test_dual_strobe();
        test_overflow16();
        test_random_ready();
        test_eof_drop();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
